systolic_tile_ctrl: RTL and testbench

Parametrised sequencer for the ROWS x COLS output-stationary systolic array. One `start` command drives one output tile through three phases: loading the operand buffers, streaming a reduction of `k_len` steps with skewed per-row and per-column valids, and draining the wavefront. It generalises the fixed 4x4 controller in three ways: runtime reduction depth, a start/busy/done handshake, and a symmetric fill/drain skew. The block sits between the operand buffers and the PE grid.

---
 rtl/systolic_tile_ctrl.sv | 111 +++++++++++
 tb/tb_systolic_tile_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_ctrl.sv
// rtl/systolic_tile_ctrl.sv - load/compute/drain sequencer for a ROWS x COLS output-stationary systolic tile
// Optional compute stall on data_valid low: define SYSTOLIC_CTRL_STALL_EN.
module systolic_tile_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int K_MAX = 16,
  parameter int CW    = $clog2(K_MAX + ROWS + COLS) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CW-1:0]   k_len,
  input  logic            data_valid,
  output logic            read_data,
  output logic [ROWS-1:0] in_valid_A,
  output logic [COLS-1:0] in_valid_B,
  output logic [ROWS-1:0] mux_select,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [CW-1:0] ld_cnt_q, ld_cnt_d;
  logic [CW-1:0] t_q, t_d;
  logic [CW-1:0] t_last;
  logic          advance;

  // Wavefront reaches the far corner PE at t = K + ROWS + COLS - 2.
  assign t_last = k_q + CW'(ROWS + COLS - 2);

`ifdef SYSTOLIC_CTRL_STALL_EN
  assign advance = data_valid;
`else
  assign advance = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      ld_cnt_q <= '0;
      t_q      <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      ld_cnt_q <= ld_cnt_d;
      t_q      <= t_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    ld_cnt_d = ld_cnt_q;
    t_d      = t_q;
    case (state_q)
      S_IDLE: begin
        if (start && (k_len != '0)) begin
          k_d      = (k_len > CW'(K_MAX)) ? CW'(K_MAX) : k_len;
          ld_cnt_d = '0;
          t_d      = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (data_valid) begin
          ld_cnt_d = ld_cnt_q + CW'(1);
          if (ld_cnt_d == k_q) begin
            state_d = S_COMPUTE;
            t_d     = '0;
          end
        end
      end
      S_COMPUTE: begin
        if (advance) begin
          if (t_q == t_last) state_d = S_DONE;
          else               t_d     = t_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    read_data  = (state_q == S_LOAD);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    in_valid_A = '0;
    in_valid_B = '0;
    mux_select = '0;
    if (state_q == S_COMPUTE) begin
      for (int i = 0; i < ROWS; i++) begin
        in_valid_A[i]          = advance && (t_q >= CW'(i)) && (t_q < CW'(i) + k_q);
        mux_select[ROWS-1-i]   = (t_q >= CW'(i));
      end
      for (int j = 0; j < COLS; j++) begin
        in_valid_B[j] = advance && (t_q >= CW'(j)) && (t_q < CW'(j) + k_q);
      end
    end
  end

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// tb/tb_systolic_tile_ctrl.sv - randomized self-checking bench for systolic_tile_ctrl
module tb_systolic_tile_ctrl;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int K_MAX = 16;
  localparam int CW    = $clog2(K_MAX + ROWS + COLS) + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [CW-1:0]   k_len;
  logic            data_valid;
  logic            read_data;
  logic [ROWS-1:0] in_valid_A;
  logic [COLS-1:0] in_valid_B;
  logic [ROWS-1:0] mux_select;
  logic            busy;
  logic            done;

  int checks   = 0;
  int failures = 0;

  logic            dv    [256];
  int              et    [256];
  logic [ROWS-1:0] obs_a [256];
  logic [ROWS-1:0] obs_m [256];

  systolic_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .data_valid(data_valid),
    .read_data(read_data), .in_valid_A(in_valid_A), .in_valid_B(in_valid_B),
    .mux_select(mux_select), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {16'd0, busy, done, read_data, in_valid_A, in_valid_B, mux_select};
  endfunction

  // mode: 0 all-ones, 1 random data_valid, 2 pattern 1,0,1,0,1, 3 two-cycle drop at cycles 7-8
  task automatic run_tile(input int k_in, input int mode, input bit inject,
                          output int done_cyc, output int rd_cnt);
    int k, l, d, acc, t, last;
    bit g, stall_en;
    logic [ROWS-1:0] ea, em;
    logic [COLS-1:0] eb;
    stall_en = 1'b0;
`ifdef SYSTOLIC_CTRL_STALL_EN
    stall_en = 1'b1;
`endif
    k = (k_in > K_MAX) ? K_MAX : k_in;
    for (int n = 0; n < 256; n++) dv[n] = (mode == 1 && n < 60) ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (mode == 2) begin dv[1] = 1; dv[2] = 0; dv[3] = 1; dv[4] = 0; dv[5] = 1; end
    if (mode == 3) begin dv[7] = 0; dv[8] = 0; end
    acc = 0; l = 0;
    for (int n = 1; n < 200; n++) begin
      if (l == 0) begin
        acc += int'(dv[n]);
        if (acc == k) l = n;
      end
    end
    last = k + ROWS + COLS - 2;
    d = 0; t = 0;
    for (int n = l + 1; n < 250; n++) begin
      if (d == 0) begin
        et[n] = t;
        g = stall_en ? dv[n] : 1'b1;
        if (t == last && g) d = n + 1;
        if (g) t++;
      end
    end
    done_cyc = -1; rd_cnt = 0;
    start = 1'b1; k_len = CW'(k_in); data_valid = dv[0];
    @(negedge clk);
    check_eq("idle_before_start", out_vec(), 32'd0);
    for (int n = 1; n <= d; n++) begin
      @(posedge clk); #1;
      start = inject && ($urandom_range(0, 7) == 0);
      k_len = CW'($urandom);
      data_valid = dv[n];
      @(negedge clk);
      obs_a[n] = in_valid_A;
      obs_m[n] = mux_select;
      if (read_data) rd_cnt++;
      if (done) done_cyc = n;
      ea = '0; eb = '0; em = '0;
      if (n > l && n < d) begin
        g = stall_en ? dv[n] : 1'b1;
        for (int i = 0; i < ROWS; i++) begin
          ea[i] = g && et[n] >= i && et[n] < i + k;
          em[ROWS-1-i] = et[n] >= i;
        end
        for (int j = 0; j < COLS; j++) eb[j] = g && et[n] >= j && et[n] < j + k;
      end
      check_eq($sformatf("k%0d_c%0d_outs", k_in, n), out_vec(),
               {16'd0, 1'b1, (n == d), (n <= l), ea, eb, em});
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic zero_start();
    start = 1'b1; k_len = '0; data_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_eq($sformatf("zero_k_c%0d", n), out_vec(), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    int dc, rc, kk;
    rst_n = 1'b0; start = 1'b0; k_len = '0; data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outs", out_vec(), 32'd0);
    rst_n = 1'b1;

    run_tile(4, 0, 1'b0, dc, rc);
    check_eq("base_done_cycle", dc, 16);
    check_eq("base_load_len", rc, 4);
    check_eq("skew_a_t0", obs_a[5], 4'b0001);
    check_eq("skew_a_t3", obs_a[8], 4'b1111);
    check_eq("skew_a_t4", obs_a[9], 4'b1110);
    check_eq("skew_a_t6", obs_a[11], 4'b1000);
    check_eq("skew_a_t7", obs_a[12], 4'b0000);
    check_eq("skew_m_t0", obs_m[5], 4'b1000);
    check_eq("skew_m_t1", obs_m[6], 4'b1100);
    check_eq("skew_m_t5", obs_m[10], 4'b1111);

    run_tile(3, 2, 1'b0, dc, rc);
    check_eq("bp_load_len", rc, 5);
    run_tile(20, 0, 1'b0, dc, rc);
    check_eq("clamp_load_len", rc, 16);
    check_eq("clamp_done_cycle", dc, 40);
    zero_start();
    run_tile(4, 0, 1'b1, dc, rc);
    check_eq("inject_done_cycle", dc, 16);

    run_tile(4, 3, 1'b0, dc, rc);
`ifdef SYSTOLIC_CTRL_STALL_EN
    check_eq("stall_done_cycle", dc, 18);
`else
    check_eq("stall_done_cycle", dc, 16);
`endif

    start = 1'b1; k_len = CW'(4); data_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check_eq("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("midtile_reset_outs", out_vec(), 32'd0);
    @(negedge clk);
    check_eq("midtile_reset_hold", out_vec(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_tile(2, 0, 1'b0, dc, rc);
    check_eq("post_reset_done_cycle", dc, 12);

    for (int r = 0; r < 25; r++) begin
      kk = $urandom_range(0, 20);
      if (kk == 0) zero_start();
      else run_tile(kk, 1, 1'b1, dc, rc);
    end

    @(negedge clk);
    check_eq("final_idle", out_vec(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=finished", checks);
    $fatal(1, "timeout");
  end
endmodule
